// File: rtl/dac_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dac_spi_arbiter
// Purpose : Two-requester arbiter in front of one shared SPI master.
//           Optional macro DAC_SPI_ARBITER_ROUND_ROBIN_EN selects round-robin
//           arbitration; fixed priority (requester 0 wins) otherwise.
// Rev     : 1.0  initial release
// ============================================================================
module dac_spi_arbiter #(
  parameter int WID = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           arm0,
  input  logic           arm1,
  input  logic [WID-1:0] to_slave0,
  input  logic [WID-1:0] to_slave1,
  output logic [WID-1:0] from_slave0,
  output logic [WID-1:0] from_slave1,
  output logic           finished0,
  output logic           finished1,
  output logic           mst_arm,
  output logic [WID-1:0] mst_to_slave,
  input  logic [WID-1:0] mst_from_slave,
  input  logic           mst_finished,
  output logic [1:0]     grant,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           owner, owner_nxt;
  logic           prio, prio_nxt;
  logic           arm_nxt;
  logic [WID-1:0] to_nxt, from0_nxt, from1_nxt;
  logic [1:0]     grant_nxt;
  logic           fin0_nxt, fin1_nxt;
  logic           winner;
  logic           owner_arm;

  assign owner_arm = owner ? arm1 : arm0;
  assign busy      = (state != IDLE);

`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
  // prio names the requester that wins a tie; it flips to the loser on every grant
  assign winner = (arm0 && arm1) ? prio : arm1;
`else
  assign winner = !arm0;
`endif

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    prio_nxt  = prio;
    arm_nxt   = mst_arm;
    to_nxt    = mst_to_slave;
    from0_nxt = from_slave0;
    from1_nxt = from_slave1;
    grant_nxt = grant;
    fin0_nxt  = finished0;
    fin1_nxt  = finished1;
    case (state)
      IDLE: begin
        // a stale mst_finished from an aborted transfer blocks new grants
        if ((arm0 || arm1) && !mst_finished) begin
          owner_nxt = winner;
          prio_nxt  = !winner;
          arm_nxt   = 1'b1;
          to_nxt    = winner ? to_slave1 : to_slave0;
          grant_nxt = winner ? 2'b10 : 2'b01;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (mst_finished) begin
          arm_nxt = 1'b0;
          if (owner) begin
            from1_nxt = mst_from_slave;
            fin1_nxt  = arm1;
          end else begin
            from0_nxt = mst_from_slave;
            fin0_nxt  = arm0;
          end
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!owner_arm && !mst_finished) begin
          fin0_nxt  = 1'b0;
          fin1_nxt  = 1'b0;
          grant_nxt = 2'b00;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= 1'b0;
      prio         <= 1'b0;
      mst_arm      <= 1'b0;
      mst_to_slave <= '0;
      from_slave0  <= '0;
      from_slave1  <= '0;
      grant        <= 2'b00;
      finished0    <= 1'b0;
      finished1    <= 1'b0;
    end else begin
      state        <= state_nxt;
      owner        <= owner_nxt;
      prio         <= prio_nxt;
      mst_arm      <= arm_nxt;
      mst_to_slave <= to_nxt;
      from_slave0  <= from0_nxt;
      from_slave1  <= from1_nxt;
      grant        <= grant_nxt;
      finished0    <= fin0_nxt;
      finished1    <= fin1_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_arbiter.sv
`default_nettype none
// Testbench for dac_spi_arbiter: cycle vector table plus directed multi-cycle
// sequences against a simple SPI master model.
module tb_dac_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm0 = 1'b0, arm1 = 1'b0;
  logic [23:0] to_slave0 = '0, to_slave1 = '0;
  logic [23:0] from_slave0, from_slave1;
  logic        finished0, finished1;
  logic        mst_arm;
  logic [23:0] mst_to_slave;
  logic [23:0] mst_from_slave;
  logic        mst_finished;
  logic [1:0]  grant;
  logic        busy;

  logic        use_model = 1'b0;
  logic        tbl_fin = 1'b0;
  logic        fin_force = 1'b0;
  logic [23:0] model_reply = '0;
  int          m_delay = 30;
  int          m_cnt = 0;
  logic        m_fin = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_spi_arbiter #(.WID(24)) dut (
    .clk(clk), .rst(rst),
    .arm0(arm0), .arm1(arm1),
    .to_slave0(to_slave0), .to_slave1(to_slave1),
    .from_slave0(from_slave0), .from_slave1(from_slave1),
    .finished0(finished0), .finished1(finished1),
    .mst_arm(mst_arm), .mst_to_slave(mst_to_slave),
    .mst_from_slave(mst_from_slave), .mst_finished(mst_finished),
    .grant(grant), .busy(busy)
  );

  // SPI master model: finishes m_delay cycles after arm, holds done until arm drops
  always @(posedge clk) begin
    if (rst || !mst_arm) begin
      m_cnt <= 0;
      m_fin <= 1'b0;
    end else if (!m_fin) begin
      if (m_cnt >= m_delay - 1) m_fin <= 1'b1;
      else m_cnt <= m_cnt + 1;
    end
  end

  assign mst_finished   = use_model ? (m_fin | fin_force) : tbl_fin;
  assign mst_from_slave = model_reply;

  typedef struct {
    logic a0, a1;
    logic [23:0] t0, t1;
    logic fin;
    logic [23:0] reply;
    logic [1:0] e_grant;
    logic e_arm, e_busy, e_f0, e_f1;
    logic [23:0] e_mto, e_from0, e_from1;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    arm0 = 1'b0;
    arm1 = 1'b0;
    fin_force = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [95:0] outs();
    return {18'b0, grant, mst_arm, busy, finished0, finished1,
            mst_to_slave, from_slave0, from_slave1};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic flag;
    logic [1:0] exp_g;
    int wait0, wait1, max_wait, viol;

    //            a0    a1    t0           t1          fin   reply        grant  arm   busy  f0    f1    mto          from0        from1
    tbl[0]  = '{1'b1, 1'b0, 24'hA5A5A5, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 24'hA5A5A5, 24'h000000, 24'h000000};
    tbl[1]  = '{1'b1, 1'b0, 24'h000001, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 24'hA5A5A5, 24'h000000, 24'h000000};
    tbl[2]  = '{1'b1, 1'b0, 24'h000001, 24'h000000, 1'b1, 24'h111111, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 24'hA5A5A5, 24'h111111, 24'h000000};
    tbl[3]  = '{1'b1, 1'b0, 24'h000001, 24'h000000, 1'b1, 24'h999999, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 24'hA5A5A5, 24'h111111, 24'h000000};
    tbl[4]  = '{1'b0, 1'b0, 24'h000001, 24'h000000, 1'b0, 24'h999999, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'hA5A5A5, 24'h111111, 24'h000000};
    tbl[5]  = '{1'b0, 1'b1, 24'h000001, 24'h222222, 1'b1, 24'h999999, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'hA5A5A5, 24'h111111, 24'h000000};
    tbl[6]  = '{1'b0, 1'b1, 24'h000001, 24'h222222, 1'b0, 24'h999999, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 24'h222222, 24'h111111, 24'h000000};
    tbl[7]  = '{1'b0, 1'b0, 24'h000001, 24'h777777, 1'b0, 24'h999999, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 24'h222222, 24'h111111, 24'h000000};
    tbl[8]  = '{1'b0, 1'b0, 24'h000001, 24'h777777, 1'b1, 24'h333333, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 24'h222222, 24'h111111, 24'h333333};
    tbl[9]  = '{1'b0, 1'b0, 24'h000001, 24'h777777, 1'b0, 24'h333333, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h222222, 24'h111111, 24'h333333};
    tbl[10] = '{1'b1, 1'b1, 24'h0000AA, 24'h222222, 1'b0, 24'h333333, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0000AA, 24'h111111, 24'h333333};
    tbl[11] = '{1'b1, 1'b1, 24'h0000AA, 24'h222222, 1'b1, 24'h444444, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0000AA, 24'h444444, 24'h333333};
    tbl[12] = '{1'b0, 1'b1, 24'h0000AA, 24'h222222, 1'b0, 24'h444444, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0000AA, 24'h444444, 24'h333333};
    tbl[13] = '{1'b0, 1'b1, 24'h0000AA, 24'h222222, 1'b0, 24'h444444, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 24'h222222, 24'h444444, 24'h333333};
    tbl[14] = '{1'b0, 1'b0, 24'h0000AA, 24'h222222, 1'b1, 24'h555555, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 24'h222222, 24'h444444, 24'h555555};
    tbl[15] = '{1'b0, 1'b0, 24'h0000AA, 24'h222222, 1'b0, 24'h555555, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 24'h222222, 24'h444444, 24'h555555};

    do_reset();
    chk("reset_outputs", outs(), 96'h0);

    // cycle-accurate vectors with mst_finished driven straight from the table
    use_model = 1'b0;
    for (int i = 0; i < 16; i++) begin
      arm0 = tbl[i].a0;  arm1 = tbl[i].a1;
      to_slave0 = tbl[i].t0;  to_slave1 = tbl[i].t1;
      tbl_fin = tbl[i].fin;   model_reply = tbl[i].reply;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          {18'b0, tbl[i].e_grant, tbl[i].e_arm, tbl[i].e_busy, tbl[i].e_f0, tbl[i].e_f1,
           tbl[i].e_mto, tbl[i].e_from0, tbl[i].e_from1});
    end
    tbl_fin = 1'b0;

    // single transfer on requester 0, to_slave0 toggling during XFER
    use_model = 1'b1;
    do_reset();
    m_delay = 30;
    model_reply = 24'h0ABCDE;
    arm0 = 1'b1;
    to_slave0 = 24'h912345;
    tick();
    chk("xfer0_grant", {grant, mst_arm, busy, mst_to_slave}, {2'b01, 1'b1, 1'b1, 24'h912345});
    n = 0; flag = 1'b0;
    while (!finished0 && n < 100) begin
      to_slave0 = ~to_slave0;
      tick();
      if (mst_to_slave !== 24'h912345 && !finished0) flag = 1'b1;
      n++;
    end
    chk("xfer0_finish_in_time", n < 100, 1);
    chk("xfer0_mto_held", flag, 0);
    chk("xfer0_from0", from_slave0, 24'h0ABCDE);
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (finished0 !== 1'b1) flag = 1'b1;
    end
    chk("xfer0_finished_held", flag, 0);
    arm0 = 1'b0;
    n = 0;
    while (busy && n < 10) begin tick(); n++; end
    chk("xfer0_idle", {busy, grant, finished0, from_slave0}, {1'b0, 2'b00, 1'b0, 24'h0ABCDE});

    // simultaneous requests from a fresh reset, then requester 0 re-requests
    do_reset();
    m_delay = 6;
    model_reply = 24'h123456;
    arm0 = 1'b1; arm1 = 1'b1;
    tick();
    chk("tie_rep1_winner", grant, 2'b01);
    n = 0;
    while (!finished0 && n < 50) begin tick(); n++; end
    arm0 = 1'b0;
    while (grant != 2'b00 && n < 80) begin tick(); n++; end
    chk("tie_rep1_in_time", n < 80, 1);
    arm0 = 1'b1;
    tick();
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
    exp_g = 2'b10;
`else
    exp_g = 2'b01;
`endif
    chk("tie_rep2_winner", grant, exp_g);
    n = 0;
    while ((arm0 || arm1 || busy) && n < 200) begin
      if (finished0) arm0 = 1'b0;
      if (finished1) arm1 = 1'b0;
      tick();
      n++;
    end
    chk("tie_drain", n < 200, 1);

    // requester 1 abandons its request mid-transfer
    m_delay = 20;
    model_reply = 24'h0F0F0F;
    arm1 = 1'b1;
    to_slave1 = 24'h100000;
    tick();
    chk("abort1_grant", {grant, mst_to_slave}, {2'b10, 24'h100000});
    repeat (3) tick();
    arm1 = 1'b0;
    n = 0; flag = 1'b0;
    while (busy && n < 60) begin
      tick();
      if (finished1) flag = 1'b1;
      n++;
    end
    chk("abort1_idle", {n < 60, busy, grant}, {1'b1, 1'b0, 2'b00});
    chk("abort1_no_finished", flag, 0);
    chk("abort1_from", {from_slave1, from_slave0}, {24'h0F0F0F, 24'h123456});

    // reset mid-transfer while the master keeps mst_finished high
    m_delay = 30;
    arm0 = 1'b1;
    tick();
    chk("rst_mid_grant", grant, 2'b01);
    repeat (10) tick();
    rst = 1'b1;
    fin_force = 1'b1;
    tick();
    chk("rst_mid_drop", {mst_arm, grant, busy}, {1'b0, 2'b00, 1'b0});
    rst = 1'b0;
    flag = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (grant != 2'b00 || mst_arm) flag = 1'b1;
    end
    chk("rst_mid_no_grant", flag, 0);
    fin_force = 1'b0;
    tick();
    chk("rst_mid_regrant", {grant, mst_arm}, {2'b01, 1'b1});
    n = 0;
    while (!finished0 && n < 100) begin tick(); n++; end
    arm0 = 1'b0;
    while (busy && n < 120) begin tick(); n++; end
    chk("rst_mid_complete", {n < 120, busy}, {1'b1, 1'b0});

    // random traffic; requesters hold until finished
    m_delay = 3;
    model_reply = 24'hC0FFEE;
    wait0 = 0; wait1 = 0; max_wait = 0; viol = 0;
    for (int c = 0; c < 10000; c++) begin
      tick();
      if (grant == 2'b11 || (finished0 && finished1)) viol++;
      if (arm0 && finished0) arm0 = 1'b0;
      else if (!arm0 && $urandom_range(3) == 0) begin arm0 = 1'b1; wait0 = 0; to_slave0 = 24'($urandom); end
      if (arm1 && finished1) arm1 = 1'b0;
      else if (!arm1 && $urandom_range(3) == 0) begin arm1 = 1'b1; wait1 = 0; to_slave1 = 24'($urandom); end
      if (arm0) begin wait0++; if (wait0 > max_wait) max_wait = wait0; end
      if (arm1) begin wait1++; if (wait1 > max_wait) max_wait = wait1; end
    end
    chk("rand_invariants", viol, 0);
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
    chk("rand_max_wait_ok", max_wait < 60, 1);
`endif
    n = 0;
    while ((arm0 || arm1 || busy) && n < 200) begin
      if (finished0) arm0 = 1'b0;
      if (finished1) arm1 = 1'b0;
      tick();
      n++;
    end
    chk("rand_drain", {n < 200, busy, grant}, {1'b1, 1'b0, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dac_spi_arbiter.md
DAC_SPI_ARBITER -- requirements
Module: dac_spi_arbiter

Interface
REQ-001 SHALL have parameter WID, default 24, SPI transfer width in bits.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports arm0 / arm1  input  1  requester transfer request, level, held until finished.
REQ-005 SHALL have ports to_slave0 / to_slave1  input  WID  requester transmit word.
REQ-006 SHALL have ports from_slave0 / from_slave1  output  WID  received word, registered.
REQ-007 SHALL have ports finished0 / finished1  output  1  requester completion, level.
REQ-008 SHALL have port mst_arm  output  1  arm to the shared SPI master.
REQ-009 SHALL have port mst_to_slave  output  WID  word to the SPI master, registered.
REQ-010 SHALL have port mst_from_slave  input  WID  word from the SPI master.
REQ-011 SHALL have port mst_finished  input  1  SPI master done; stays high until mst_arm drops.
REQ-012 SHALL have port grant  output  2  one-hot current owner; 00 when idle.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-014 SHALL implement states IDLE, XFER, DONE.
REQ-015 IDLE: on an edge with at least one armN high and mst_finished low, SHALL select a winner, load mst_to_slave from to_slaveN, set mst_arm=1, set grant, and enter XFER; mst_arm is visible one cycle after armN is sampled.
REQ-016 IDLE with mst_finished high SHALL grant nothing.
REQ-017 XFER: on mst_finished high, SHALL latch mst_from_slave into from_slaveN, set mst_arm=0, set finishedN=1 only if armN is still high, and enter DONE.
REQ-018 A requester that drops armN during XFER SHALL NOT abort the SPI transfer; the transfer completes, from_slaveN updates, and finishedN stays 0.
REQ-019 DONE: when armN is low and mst_finished is low, SHALL clear finishedN and grant, and enter IDLE; finishedN stays high while armN stays high.
REQ-020 A losing requester's armN SHALL stay pending, without timeout, and SHALL be granted on the first qualifying IDLE edge.
REQ-021 mst_to_slave SHALL hold constant from grant until the return to IDLE, regardless of changes on to_slaveN.
REQ-022 from_slaveN SHALL change only on completion of a transfer owned by requester N.
REQ-023 At most one finishedN and one grant bit SHALL be high at any time.
REQ-024 Minimum back-to-back turnaround SHALL be one IDLE cycle between DONE and the next mst_arm.

Reset
REQ-025 On rst, SHALL set state=IDLE, mst_arm=0, mst_to_slave=0, grant=00, busy=0, finished0/1=0, from_slave0/1=0, and the round-robin pointer to favour requester 0.
REQ-026 rst asserted mid-XFER SHALL drop mst_arm on the next edge, and no grant SHALL follow until mst_finished is observed low.

Configuration
REQ-027 With macro DAC_SPI_ARBITER_ROUND_ROBIN_EN defined, simultaneous requests SHALL be resolved round-robin: the requester not served last wins, and the pointer updates on each grant.
REQ-028 Without DAC_SPI_ARBITER_ROUND_ROBIN_EN, requester 0 SHALL always win simultaneous requests (fixed priority); requester 1 may starve.

Verification
REQ-029 arm0=1, to_slave0=24'h912345; model master finishes 30 cycles after arm -> mst_arm high 1 cycle after arm0; mst_to_slave=24'h912345; grant=01; from_slave0 = model reply 24'h0ABCDE; finished0 held until arm0 drops; then IDLE, busy=0.
REQ-030 arm0 and arm1 raised on the same edge, both held, RR enabled -> requester 0 served first, then requester 1; repeating the stimulus serves requester 1 first. With RR disabled -> requester 0 first on both repetitions.
REQ-031 arm1=1 with to_slave1=24'h100000, then arm1 dropped mid-XFER -> transfer completes; from_slave1 updated; finished1 never high; return to IDLE.
REQ-032 rst pulsed 10 cycles into XFER while the model holds mst_finished high for 3 further cycles, with arm0 high -> mst_arm=0 the next cycle; no new grant until mst_finished low; then arm0 re-granted.
REQ-033 to_slave0 toggled every cycle during XFER -> mst_to_slave stays at the value captured at grant.
REQ-034 Random arm0/arm1 traffic, 10k cycles -> grant never 11, finished0 and finished1 never both high, every held request is eventually served (RR build).
